// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared state encodings and defaults for the input conditioning FSMs
package fsm_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } debounce_state_t;

    localparam int DEBOUNCE_DEFAULT = 16;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - N-flop synchronizer for an asynchronous single-bit input
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronizes and debounces one raw input into a clean level with edge pulses
module input_debouncer
    import fsm_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic clean_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            sync_in;
    debounce_state_t state, next_state;
    logic [CNT_W-1:0] count, next_count;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (sync_in)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= STABLE_LO;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // A revert during WAIT_* drops back to the old stable state and restarts the count.
    always_comb begin
        next_state = state;
        next_count = count;
        case (state)
            STABLE_LO: begin
                if (sync_in) begin
                    next_state = WAIT_HI;
                    next_count = '0;
                end
            end
            WAIT_HI: begin
                if (!sync_in) begin
                    next_state = STABLE_LO;
                    next_count = '0;
                end else if (count == CNT_LAST) begin
                    next_state = STABLE_HI;
                    next_count = '0;
                end else begin
                    next_count = count + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!sync_in) begin
                    next_state = WAIT_LO;
                    next_count = '0;
                end
            end
            WAIT_LO: begin
                if (sync_in) begin
                    next_state = STABLE_HI;
                    next_count = '0;
                end else if (count == CNT_LAST) begin
                    next_state = STABLE_LO;
                    next_count = '0;
                end else begin
                    next_count = count + CNT_W'(1);
                end
            end
            default: begin
                next_state = STABLE_LO;
                next_count = '0;
            end
        endcase
    end

    // Outputs are registered from next_state so pulses line up with the first new clean_out cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clean_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            stable     <= 1'b1;
        end else begin
            clean_out  <= (next_state == STABLE_HI) || (next_state == WAIT_LO);
            rise_pulse <= (state == WAIT_HI) && (next_state == STABLE_HI);
            fall_pulse <= (state == WAIT_LO) && (next_state == STABLE_LO);
            stable     <= (next_state == STABLE_LO) || (next_state == STABLE_HI);
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed self-checking bench for input_debouncer
module tb_input_debouncer;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic raw_in = 1'b0;
    logic clean_out, rise_pulse, fall_pulse, stable;

    int n_cmp = 0;
    int n_bad = 0;

    // Small downstream Moore FSM fed by clean_out.
    logic ds_active;
    logic output_signal;

    input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .stable     (stable)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ds_active <= 1'b0;
        else       ds_active <= clean_out;
    end
    assign output_signal = ds_active;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".clean"}, clean_out, 1'b0);
        check({tag, ".rise"}, rise_pulse, 1'b0);
        check({tag, ".fall"}, fall_pulse, 1'b0);
        check({tag, ".stable"}, stable, 1'b1);
    endtask

    // Runs n edges; clean_out is c0 before edge chg and c1 from edge chg on (chg=0: no change).
    task automatic track(input string tag, input int n, input logic c0, input logic c1, input int chg);
        for (int i = 1; i <= n; i++) begin
            logic ce, re, fe, se;
            tick();
            ce = (chg > 0 && i >= chg) ? c1 : c0;
            re = (chg == i) && c1 && !c0;
            fe = (chg == i) && !c1 && c0;
            se = !(chg > 0 && i >= chg - D && i < chg);
            check($sformatf("%s.clean@%0d", tag, i), clean_out, ce);
            check($sformatf("%s.rise@%0d", tag, i), rise_pulse, re);
            check($sformatf("%s.fall@%0d", tag, i), fall_pulse, fe);
            if (chg > 0) check($sformatf("%s.stable@%0d", tag, i), stable, se);
        end
    endtask

    initial begin
        // Reset asserted mid-cycle with raw_in high: outputs go to reset values without a clock.
        raw_in = 1'b1;
        #7;
        reset = 1'b1;
        #1;
        check_reset_values("rst_async");
        tick();
        tick();
        check_reset_values("rst_hold");
        reset = 1'b0;

        // raw_in held high through release gives one normal debounced rise.
        track("rst_rise", 9, 1'b0, 1'b1, 7);

        // Clean fall.
        raw_in = 1'b0;
        track("fall", 9, 1'b1, 1'b0, 7);

        // Short high excursion of 3 cycles is rejected.
        raw_in = 1'b1;
        track("bnc_a", 3, 1'b0, 1'b0, 0);
        raw_in = 1'b0;
        track("bnc_b", 7, 1'b0, 1'b0, 0);
        check("bnc.stable", stable, 1'b1);

        // 1-0-1-0 every 2 cycles for 40 cycles.
        for (int k = 0; k < 10; k++) begin
            raw_in = 1'b1;
            track($sformatf("sq%0d_hi", k), 2, 1'b0, 1'b0, 0);
            raw_in = 1'b0;
            track($sformatf("sq%0d_lo", k), 2, 1'b0, 1'b0, 0);
        end
        track("sq_tail", 6, 1'b0, 1'b0, 0);
        check("sq.stable", stable, 1'b1);

        // Clean rise from a quiet low level, then fall back.
        raw_in = 1'b1;
        track("rise", 9, 1'b0, 1'b1, 7);
        raw_in = 1'b0;
        track("fall2", 9, 1'b1, 1'b0, 7);

        // Reset while WAIT_HI has counted to 2.
        raw_in = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("wait.clean@%0d", i), clean_out, 1'b0);
            check($sformatf("wait.stable@%0d", i), stable, (i < 3));
        end
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("rst_mid");
        tick();
        tick();
        check_reset_values("rst_mid_hold");
        reset = 1'b0;
        track("rst_mid_rise", 9, 1'b0, 1'b1, 7);
        raw_in = 1'b0;
        track("fall3", 9, 1'b1, 1'b0, 7);

        // 8-cycle raw pulse through the downstream FSM.
        raw_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 8) raw_in = 1'b0;
            check($sformatf("ds.clean@%0d", i), clean_out, (i >= 7 && i <= 14));
            check($sformatf("ds.rise@%0d", i), rise_pulse, (i == 7));
            check($sformatf("ds.fall@%0d", i), fall_pulse, (i == 15));
            check($sformatf("ds.out@%0d", i), output_signal, (i >= 8 && i <= 15));
        end
        check("ds.idle", output_signal, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
